// File: rtl/fb_write_sched_pkg.sv
// Shared types and constants for the framebuffer write scheduler.
package fb_write_sched_pkg;

  localparam int NPIX_DEF = 512;   // pixels per frame (power of two)
  localparam int RGB_W    = 24;    // pixel data width

  // Fill-pass sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_SWAP = 2'd2
  } fill_state_e;

endpackage

// File: rtl/fb_write_sched_wr_mux.sv
// Registered 2:1 write mux: host has strict priority over the generator.
// The strobe is high only in the cycle after an accepted write; address
// and data hold their last values otherwise.
module fb_wr_mux
  import fb_write_sched_pkg::*;
#(
  parameter int AW = 9
) (
  input  logic             pixclk,
  input  logic             reset,
  input  logic             host_req,
  input  logic [AW-1:0]    host_addr,
  input  logic [RGB_W-1:0] host_rgb,
  input  logic             gen_we,
  input  logic [AW-1:0]    gen_addr,
  input  logic [RGB_W-1:0] gen_rgb,
  output logic             fb_we,
  output logic [AW-1:0]    fb_addr,
  output logic [RGB_W-1:0] fb_rgb
);

  logic             we_d,   we_q;
  logic [AW-1:0]    addr_d, addr_q;
  logic [RGB_W-1:0] rgb_d,  rgb_q;

  // Select the winning write source; hold address/data when nothing is written
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    rgb_d  = rgb_q;
    if (host_req) begin
      we_d   = 1'b1;
      addr_d = host_addr;
      rgb_d  = host_rgb;
    end else if (gen_we) begin
      we_d   = 1'b1;
      addr_d = gen_addr;
      rgb_d  = gen_rgb;
    end
  end

  // Output write port registers
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      we_q   <= 1'b0;
      addr_q <= '0;
      rgb_q  <= '0;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      rgb_q  <= rgb_d;
    end
  end

  assign fb_we   = we_q;
  assign fb_addr = addr_q;
  assign fb_rgb  = rgb_q;

endmodule

// File: rtl/fb_write_sched.sv
// Double-buffered framebuffer write scheduler. A frame_tick starts one
// fill pass of the back bank from the pattern generator; after the last
// pixel the banks swap. Host writes pre-empt the generator at any time and
// land in whichever bank is the back bank when the strobe appears.
module fb_write_sched
  import fb_write_sched_pkg::*;
#(
  parameter int NPIX = NPIX_DEF,
  parameter int FCW  = 13,
  localparam int AW  = $clog2(NPIX)
) (
  input  logic             pixclk,
  input  logic             reset,
  input  logic             frame_tick,
  output logic [AW-1:0]    gen_addr,
  output logic [FCW-1:0]   gen_frame,
  input  logic             gen_valid,
  input  logic [RGB_W-1:0] gen_rgb,
  output logic             gen_ready,
  input  logic             host_req,
  input  logic [AW-1:0]    host_addr,
  input  logic [RGB_W-1:0] host_rgb,
  output logic             host_gnt,
  output logic             fb_we,
  output logic [AW-1:0]    fb_addr,
  output logic [RGB_W-1:0] fb_rgb,
  output logic             fb_bank,
  output logic             disp_bank,
  output logic             busy,
  output logic             overrun
);

  fill_state_e    state_d, state_q;
  logic [AW-1:0]  ptr_d,   ptr_q;
  logic [FCW-1:0] frame_d, frame_q;
  logic           disp_d,  disp_q;
  logic           ovr_d,   ovr_q;
  logic           gen_we;

  // The generator is only served while filling and while the host is quiet
  assign gen_ready = (state_q == ST_FILL) && !host_req;
  assign gen_we    = gen_ready && gen_valid;
  assign host_gnt  = host_req;
  assign busy      = (state_q != ST_IDLE);

  // Next-state logic: fill pointer, bank swap, frame count, overrun detect
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    frame_d = frame_q;
    disp_d  = disp_q;
    // A tick while busy (including the SWAP cycle) is dropped and flagged
    ovr_d   = frame_tick && busy;
    case (state_q)
      ST_IDLE: begin
        if (frame_tick) begin
          state_d = ST_FILL;
          ptr_d   = '0;
        end
      end
      ST_FILL: begin
        if (gen_we) begin
          // Pointer wraps naturally to 0 because NPIX is a power of two
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == AW'(NPIX - 1)) state_d = ST_SWAP;
        end
      end
      ST_SWAP: begin
        disp_d  = ~disp_q;
        frame_d = frame_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state registers
  always_ff @(posedge pixclk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      frame_q <= '0;
      disp_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      frame_q <= frame_d;
      disp_q  <= disp_d;
      ovr_q   <= ovr_d;
    end
  end

  fb_wr_mux #(.AW(AW)) u_wr_mux (
    .pixclk    (pixclk),
    .reset     (reset),
    .host_req  (host_req),
    .host_addr (host_addr),
    .host_rgb  (host_rgb),
    .gen_we    (gen_we),
    .gen_addr  (ptr_q),
    .gen_rgb   (gen_rgb),
    .fb_we     (fb_we),
    .fb_addr   (fb_addr),
    .fb_rgb    (fb_rgb)
  );

  assign gen_addr  = ptr_q;
  assign gen_frame = frame_q;
  assign disp_bank = disp_q;
  assign fb_bank   = ~disp_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Scoreboard bench for fb_write_sched: stimulus pushes expected writes,
// a negedge monitor pops and compares each fb_we strobe.
module tb_fb_write_sched;

  logic        pixclk = 1'b0;
  logic        reset;
  logic        frame_tick, gen_valid, host_req;
  logic [8:0]  gen_addr, host_addr, fb_addr;
  logic [12:0] gen_frame;
  logic [23:0] gen_rgb, host_rgb, fb_rgb;
  logic        gen_ready, host_gnt, fb_we, fb_bank, disp_bank, busy, overrun;

  typedef struct packed {
    logic [8:0]  addr;
    logic [23:0] rgb;
    logic        bank;
  } wr_t;

  wr_t exp_q[$];
  wr_t m_e;
  int  checks   = 0;
  int  failures = 0;

  always #5 pixclk = ~pixclk;

  // Pattern generator stand-in: pixel colour depends on address and frame
  function automatic logic [23:0] px(input logic [8:0] a, input logic [12:0] f);
    return {f[7:0] ^ 8'h5A, 7'd0, a};
  endfunction

  assign gen_rgb = px(gen_addr, gen_frame);

  fb_write_sched dut (
    .pixclk(pixclk), .reset(reset), .frame_tick(frame_tick),
    .gen_addr(gen_addr), .gen_frame(gen_frame), .gen_valid(gen_valid),
    .gen_rgb(gen_rgb), .gen_ready(gen_ready), .host_req(host_req),
    .host_addr(host_addr), .host_rgb(host_rgb), .host_gnt(host_gnt),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_rgb(fb_rgb), .fb_bank(fb_bank),
    .disp_bank(disp_bank), .busy(busy), .overrun(overrun)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write
  always @(negedge pixclk) begin
    if (!reset && fb_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write addr=%0d rgb=%0h t=%0t", fb_addr, fb_rgb, $time);
      end else begin
        m_e = exp_q.pop_front();
        chk("wr_addr", 32'(fb_addr), 32'(m_e.addr));
        chk("wr_rgb",  32'(fb_rgb),  32'(m_e.rgb));
        chk("wr_bank", 32'(fb_bank), 32'(m_e.bank));
      end
    end
  end

  task automatic step(input logic h, input logic [8:0] ha, input logic [23:0] hr,
                      input logic gv, input logic tk);
    host_req = h; host_addr = ha; host_rgb = hr; gen_valid = gv; frame_tick = tk;
    @(posedge pixclk); #1;
  endtask

  task automatic idle();
    step(1'b0, 9'd0, 24'd0, 1'b0, 1'b0);
  endtask

  task automatic gen_fill(input int start, input int n, input int fr, input logic bank);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{addr: 9'(start + i), rgb: px(9'(start + i), 13'(fr)), bank: bank});
      step(1'b0, 9'd0, 24'd0, 1'b1, 1'b0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gen_addr"},  32'(gen_addr),  32'd0);
    chk({tag, "_gen_frame"}, 32'(gen_frame), 32'd0);
    chk({tag, "_disp_bank"}, 32'(disp_bank), 32'd0);
    chk({tag, "_fb_bank"},   32'(fb_bank),   32'd1);
    chk({tag, "_fb_we"},     32'(fb_we),     32'd0);
    chk({tag, "_fb_addr"},   32'(fb_addr),   32'd0);
    chk({tag, "_fb_rgb"},    32'(fb_rgb),    32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_overrun"},   32'(overrun),   32'd0);
  endtask

  initial begin
    reset = 1'b1;
    host_req = 1'b0; host_addr = '0; host_rgb = '0; gen_valid = 1'b0; frame_tick = 1'b0;
    #12;
    chk_reset_vals("rst");
    @(posedge pixclk); #1;
    reset = 1'b0;
    idle(); idle();

    // Host write while idle
    exp_q.push_back('{addr: 9'd5, rgb: 24'hFF0000, bank: 1'b1});
    host_req = 1'b1; host_addr = 9'd5; host_rgb = 24'hFF0000; gen_valid = 1'b1;
    #1;
    chk("idle_host_gnt", 32'(host_gnt), 32'd1);
    chk("idle_gen_ready", 32'(gen_ready), 32'd0);
    @(posedge pixclk); #1;
    chk("idle_fb_we_lat1", 32'(fb_we), 32'd1);
    idle();
    chk("idle_fb_we_off", 32'(fb_we), 32'd0);
    chk("idle_fb_addr_hold", 32'(fb_addr), 32'd5);

    // Full frame with gen_valid held high: 514 cycles tick to idle
    step(1'b0, 9'd0, 24'd0, 1'b1, 1'b1);
    chk("f0_busy", 32'(busy), 32'd1);
    gen_fill(0, 512, 0, 1'b1);
    chk("f0_swap_busy", 32'(busy), 32'd1);
    chk("f0_swap_ready", 32'(gen_ready), 32'd0);
    chk("f0_swap_ptr", 32'(gen_addr), 32'd0);
    step(1'b0, 9'd0, 24'd0, 1'b1, 1'b0);
    chk("f0_done_busy", 32'(busy), 32'd0);
    chk("f0_disp_bank", 32'(disp_bank), 32'd1);
    chk("f0_fb_bank", 32'(fb_bank), 32'd0);
    chk("f0_gen_frame", 32'(gen_frame), 32'd1);

    // Host stalls generator at pointer 100; tick during SWAP is dropped
    step(1'b0, 9'd0, 24'd0, 1'b0, 1'b1);
    gen_fill(0, 100, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back('{addr: 9'(400 + k), rgb: 24'(32'h00AB00 + k), bank: 1'b0});
      step(1'b1, 9'(400 + k), 24'(32'h00AB00 + k), 1'b1, 1'b0);
      chk("stall_gen_addr", 32'(gen_addr), 32'd100);
      chk("stall_gen_ready", 32'(gen_ready), 32'd0);
    end
    gen_fill(100, 412, 1, 1'b0);
    step(1'b0, 9'd0, 24'd0, 1'b0, 1'b1);
    chk("swaptick_overrun", 32'(overrun), 32'd1);
    chk("swaptick_busy", 32'(busy), 32'd0);
    chk("f1_disp_bank", 32'(disp_bank), 32'd0);
    chk("f1_gen_frame", 32'(gen_frame), 32'd2);
    idle();
    chk("swaptick_ovr_clr", 32'(overrun), 32'd0);
    chk("swaptick_dropped", 32'(busy), 32'd0);

    // Tick during fill at pointer 200
    step(1'b0, 9'd0, 24'd0, 1'b0, 1'b1);
    gen_fill(0, 200, 2, 1'b1);
    exp_q.push_back('{addr: 9'd200, rgb: px(9'd200, 13'd2), bank: 1'b1});
    step(1'b0, 9'd0, 24'd0, 1'b1, 1'b1);
    chk("ovr_pulse", 32'(overrun), 32'd1);
    chk("ovr_busy", 32'(busy), 32'd1);
    gen_fill(201, 1, 2, 1'b1);
    chk("ovr_one_cycle", 32'(overrun), 32'd0);
    gen_fill(202, 310, 2, 1'b1);
    idle();
    chk("f2_disp_bank", 32'(disp_bank), 32'd1);
    chk("f2_gen_frame", 32'(gen_frame), 32'd3);
    idle(); idle();
    chk("f2_single_swap", 32'(disp_bank), 32'd1);
    chk("f2_idle", 32'(busy), 32'd0);

    // Generator valid every other cycle
    step(1'b0, 9'd0, 24'd0, 1'b0, 1'b1);
    chk("f3_fb_bank", 32'(fb_bank), 32'd0);
    for (int i = 0; i < 1024; i++) begin
      if (i % 2 == 0) begin
        exp_q.push_back('{addr: 9'(i / 2), rgb: px(9'(i / 2), 13'd3), bank: 1'b0});
        step(1'b0, 9'd0, 24'd0, 1'b1, 1'b0);
      end else begin
        step(1'b0, 9'd0, 24'd0, 1'b0, 1'b0);
        chk("toggle_stall_we", 32'(fb_we), 32'd0);
      end
    end
    chk("f3_busy", 32'(busy), 32'd0);
    chk("f3_disp_bank", 32'(disp_bank), 32'd0);
    chk("f3_gen_frame", 32'(gen_frame), 32'd4);

    // Reset mid-fill at pointer 300
    step(1'b0, 9'd0, 24'd0, 1'b0, 1'b1);
    gen_fill(0, 300, 4, 1'b1);
    gen_valid = 1'b0;
    chk("mid_gen_addr", 32'(gen_addr), 32'd300);
    @(negedge pixclk); #1;
    reset = 1'b1;
    #1;
    chk_reset_vals("async");
    @(posedge pixclk); #1;
    reset = 1'b0;
    idle();
    step(1'b0, 9'd0, 24'd0, 1'b0, 1'b1);
    gen_fill(0, 4, 0, 1'b1);
    chk("restart_gen_addr", 32'(gen_addr), 32'd4);
    idle(); idle();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fb_write_sched.md
FB_WRITE_SCHED -- requirements
Module: fb_write_sched

Interface
REQ-001 Parameter: NPIX, 512, pixels per frame; power of two; addresses are log2(NPIX) bits (9 at default).
REQ-002 Parameter: FCW, 13, width of frame counter.
REQ-003 pixclk  in  1  clock; all logic is on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 frame_tick  in  1  single-cycle pulse, already in the pixclk domain; requests one fill pass.
REQ-006 gen_addr  out  9  pixel index the pattern generator must render next.
REQ-007 gen_frame  out  FCW  frame index for the pattern generator (animation phase).
REQ-008 gen_valid  in  1  generator holds gen_rgb valid for gen_addr.
REQ-009 gen_rgb  in  24  generator pixel data.
REQ-010 gen_ready  out  1  scheduler accepts the generator pixel this cycle.
REQ-011 host_req  in  1  host (e.g. UART loader) requests a single-pixel write.
REQ-012 host_addr  in  9  host pixel address.
REQ-013 host_rgb  in  24  host pixel data.
REQ-014 host_gnt  out  1  host write accepted this cycle (combinational, equals host_req).
REQ-015 fb_we  out  1  registered framebuffer write strobe.
REQ-016 fb_addr  out  9  registered write address.
REQ-017 fb_rgb  out  24  registered write data.
REQ-018 fb_bank  out  1  bank being written (back bank); equals ~disp_bank.
REQ-019 disp_bank  out  1  bank the scan-out reads.
REQ-020 busy  out  1  high in FILL and SWAP.
REQ-021 overrun  out  1  one-cycle pulse when frame_tick arrives while busy.

Function
REQ-022 FSM states: IDLE, FILL, SWAP; reset state is IDLE.
REQ-023 IDLE: frame_tick -> FILL with fill pointer = 0; otherwise stay.
REQ-024 FILL: gen_ready = ~host_req; a generator write occurs when gen_valid & gen_ready.
REQ-025 On a generator write: fb_addr <= pointer, fb_rgb <= gen_rgb, fb_we <= 1, pointer increments.
REQ-026 Generator write at pointer == NPIX-1 -> SWAP; the pointer wraps to 0.
REQ-027 SWAP lasts exactly one cycle: disp_bank toggles, gen_frame increments mod 2^FCW, then IDLE.
REQ-028 Host has strict priority in every state; a granted host write drives fb_addr <= host_addr, fb_rgb <= host_rgb, fb_we <= 1 to the current back bank.
REQ-029 Simultaneous host_req and gen_valid in FILL: host write only; the generator stalls and the pointer holds.
REQ-030 gen_ready is 0 in IDLE and SWAP; gen_valid there is ignored.
REQ-031 fb_we is 0 in any cycle without a granted write; fb_addr and fb_rgb hold their last values.
REQ-032 Write latency: exactly 1 pixclk from the accepting edge to fb_we high.
REQ-033 gen_addr equals the fill pointer, registered, stable while the generator stalls.
REQ-034 frame_tick in FILL or SWAP is dropped (no queueing) and pulses overrun on the next cycle.
REQ-035 frame_tick in the same cycle as the SWAP->IDLE transition counts as busy: the tick is dropped and overrun pulses.

Reset
REQ-036 Reset forces: state IDLE, pointer 0, gen_addr 0, gen_frame 0, disp_bank 0 (fb_bank 1), fb_we 0, fb_addr 0, fb_rgb 0, busy 0, overrun 0.
REQ-037 Reset mid-FILL abandons the pass; the back bank contents are undefined and no swap occurs.

Structure
REQ-038 A shared package holds the FSM state enum, the NPIX default, and the RGB width constant (24).
REQ-039 One sub-module, fb_wr_mux: a registered 2:1 host/generator write mux producing fb_we, fb_addr, and fb_rgb.

Verification
REQ-040 Reset, one frame_tick, gen_valid held high -> 512 consecutive fb_we with fb_addr 0..511, then SWAP; disp_bank 0->1, gen_frame 0->1, busy low 514 cycles after the tick.
REQ-041 host_req high for 3 cycles at pointer 100 -> three host writes at host_addr; the generator stalls with gen_addr = 100; fill completes 3 cycles later.
REQ-042 frame_tick at pointer 200 -> overrun pulses once; only one swap occurs; a later idle tick starts a new fill with fb_bank = 0.
REQ-043 gen_valid toggled every other cycle -> fb_addr sequence has no gaps or repeats; fb_we is low on stalled cycles.
REQ-044 Reset asserted at pointer 300 -> all outputs reach their reset values immediately; the next tick restarts from address 0 with disp_bank 0.
REQ-045 Host write in IDLE to address 5 with rgb 24'hFF0000 -> fb_we with fb_addr 5 and fb_bank = ~disp_bank, one cycle later.
